// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   div_state_t : divider FSM encoding (IDLE, BUSY, DONE)
//   DIV_ZERO_Q  : quotient pattern returned on divide-by-zero (all ones,
//                 truncated to the instance WIDTH)
//   MAX_WIDTH   : widest legal operand width
package div_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
//   master : operand source + result sink side
//   slave  : the divider
//   in_valid/in_ready/dividend/divisor             operand channel
//   out_valid/out_ready/quotient/remainder/div_zero result channel
//   busy                                           iteration in progress
interface seq_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, busy
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   r_in  : WIDTH+1 partial remainder     q_in : quotient/dividend shift reg
//   d     : divisor magnitude
//   r_out : next partial remainder        q_out: next shift reg, new bit in LSB
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic             w_unused_msb;

    // Shift next dividend bit into the remainder, then trial-subtract.
    assign w_shift  = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, d};
    // Borrow out of the subtractor means shifted remainder < divisor.
    assign w_borrow = w_diff[WIDTH+1];

    assign r_out = w_borrow ? w_shift : w_diff[WIDTH:0];
    assign q_out = {q_in[WIDTH-2:0], ~w_borrow};

    // Partial remainder stays below the divisor, so its MSB is always 0 here.
    assign w_unused_msb = r_in[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per clock.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_divider_if.slave (operand/result handshakes, busy)
// Latency: WIDTH+1 cycles from accept to out_valid (1 for divide-by-zero).
// Optional macro DIV_SIGNED_EN: two's-complement operands and results.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH:0]   w_step_r;
    logic [WIDTH-1:0] w_step_q;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_r),
        .q_in  (r_q),
        .d     (r_d),
        .r_out (w_step_r),
        .q_out (w_step_q)
    );

`ifdef DIV_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic w_accept;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg  = bus.dividend[WIDTH-1];
    assign w_b_neg  = bus.divisor[WIDTH-1];
    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_a_mag  = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_mag  = w_b_neg ? -bus.divisor  : bus.divisor;

    // Result signs captured with the operands; applied on the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end

    assign w_q_fix = r_neg_q ? -w_step_q : w_step_q;
    assign w_r_fix = r_neg_r ? -w_step_r[WIDTH-1:0] : w_step_r[WIDTH-1:0];
`else
    assign w_a_mag = bus.dividend;
    assign w_b_mag = bus.divisor;
    assign w_q_fix = w_step_q;
    assign w_r_fix = w_step_r[WIDTH-1:0];
`endif

    // Control FSM, iteration datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dz        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (bus.divisor == '0) begin
                            r_quot      <= WIDTH'(DIV_ZERO_Q);
                            r_rem       <= bus.dividend;
                            r_dz        <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_r     <= '0;
                            r_q     <= w_a_mag;
                            r_d     <= w_b_mag;
                            r_cnt   <= CNT_W'(WIDTH);
                            r_dz    <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_r   <= w_step_r;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last iteration: publish the (sign-corrected) result directly.
                    if (r_cnt == CNT_W'(1)) begin
                        r_quot      <= w_q_fix;
                        r_rem       <= w_r_fix;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_zero  = r_dz;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: 8-bit and 4-bit instances, directed
// scenarios plus randomized operands against an arithmetic reference model.
// Honours DIV_SIGNED_EN the same way the design does.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8)) b8 ();
    seq_divider_if #(.WIDTH(4)) b4 ();

    seq_divider #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
    seq_divider #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    // Reference: plain integer division on w-bit values.
    function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint mask, la, lb, lq, lr;
        mask = (longint'(1) << w) - 1;
        la   = longint'(a) & mask;
        lb   = longint'(b) & mask;
`ifdef DIV_SIGNED_EN
        if (((la >> (w - 1)) & 1) == 1) la = la - (longint'(1) << w);
        if (((lb >> (w - 1)) & 1) == 1) lb = lb - (longint'(1) << w);
`endif
        if (lb == 0) begin
            lq = mask;
            lr = la;
            dz = 1'b1;
        end else begin
            lq = la / lb;
            lr = la % lb;
            dz = 1'b0;
        end
        q = 32'(lq & mask);
        r = 32'(lr & mask);
    endfunction

    // One full transaction on the 8-bit DUT (out_ready assumed high).
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic dz, output int lat);
        int n = 0;
        while (b8.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        b8.dividend = a;
        b8.divisor  = b;
        b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        lat = 1;
        while (b8.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        q  = b8.quotient;
        r  = b8.remainder;
        dz = b8.div_zero;
        @(posedge clk); #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r, output logic dz, output int lat);
        int n = 0;
        while (b4.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        b4.dividend = a;
        b4.divisor  = b;
        b4.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        lat = 1;
        while (b4.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        q  = b4.quotient;
        r  = b4.remainder;
        dz = b4.div_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b8.in_valid = 1'b0; b8.dividend = '0; b8.divisor = '0; b8.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.dividend = '0; b4.divisor = '0; b4.out_ready = 1'b1;
        #12;
        checks++; if (b8.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", b8.in_ready); end
        checks++; if (b8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", b8.out_valid); end
        checks++; if (b8.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", b8.busy); end
        checks++; if (b8.div_zero !== 1'b0)  begin errors++; $display("FAIL reset_div_zero got %b exp 0", b8.div_zero); end
        checks++; if ({b8.quotient, b8.remainder} !== 16'h0000)
            begin errors++; $display("FAIL reset_q_r got %h/%h exp 00/00", b8.quotient, b8.remainder); end
        checks++; if ({b4.in_ready, b4.out_valid} !== 2'b10)
            begin errors++; $display("FAIL reset_w4 got rdy=%b vld=%b exp 1/0", b4.in_ready, b4.out_valid); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [7:0] q, r; logic dz; int lat;
        logic [31:0] eq, er; logic edz;
        run8(8'd200, 8'd7, q, r, dz, lat);
        ref_div(8, 32'd200, 32'd7, eq, er, edz);
`ifndef DIV_SIGNED_EN
        checks++; if ({q, r} !== {8'd28, 8'd4}) begin errors++; $display("FAIL basic_200_7 got %0d r %0d exp 28 r 4", q, r); end
`endif
        checks++; if ({q, r, dz} !== {eq[7:0], er[7:0], edz})
            begin errors++; $display("FAIL basic_model got %h/%h/%b exp %h/%h/%b", q, r, dz, eq[7:0], er[7:0], edz); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d exp 9", lat); end
    endtask

    task automatic test_div_zero;
        logic [7:0] q, r; logic dz; int lat;
        run8(8'd15, 8'd0, q, r, dz, lat);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dz_quot got %h exp ff", q); end
        checks++; if (r !== 8'd15) begin errors++; $display("FAIL dz_rem got %0d exp 15", r); end
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", dz); end
        checks++; if (lat !== 1)   begin errors++; $display("FAIL dz_latency got %0d exp 1", lat); end
        // A following normal divide must clear the flag.
        run8(8'd9, 8'd3, q, r, dz, lat);
        checks++; if ({q, r, dz} !== {8'd3, 8'd0, 1'b0})
            begin errors++; $display("FAIL dz_clear got %0d/%0d/%b exp 3/0/0", q, r, dz); end
    endtask

    task automatic test_backpressure;
        int n = 0;
        b8.out_ready = 1'b0;
        b8.dividend = 8'd100; b8.divisor = 8'd10; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        while (b8.out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            b8.dividend = 8'd9; b8.divisor = 8'd3; b8.in_valid = 1'b1;
            checks++;
            if (b8.out_valid !== 1'b1 || b8.quotient !== 8'd10 || b8.remainder !== 8'd0 || b8.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got vld=%b q=%0d r=%0d rdy=%b exp 1/10/0/0",
                         i, b8.out_valid, b8.quotient, b8.remainder, b8.in_ready);
            end
            @(posedge clk); #1;
        end
        b8.in_valid = 1'b0;
        checks++; if ({b8.out_valid, b8.quotient} !== {1'b1, 8'd10})
            begin errors++; $display("FAIL bp_after got vld=%b q=%0d exp 1/10", b8.out_valid, b8.quotient); end
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({b8.out_valid, b8.in_ready} !== 2'b01)
            begin errors++; $display("FAIL bp_release got vld=%b rdy=%b exp 0/1", b8.out_valid, b8.in_ready); end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0) n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL bp_no_capture got %0d active cycles exp 0", n); end
    endtask

    task automatic test_reset_abort;
        logic [7:0] q, r; logic dz; int lat; int n = 0;
        b8.dividend = 8'd200; b8.divisor = 8'd7; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (b8.busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b exp 1", b8.busy); end
        rst = 1'b1;
        #1;
        checks++; if ({b8.out_valid, b8.in_ready, b8.busy} !== 3'b010)
            begin errors++; $display("FAIL abort_immediate got vld=%b rdy=%b busy=%b exp 0/1/0", b8.out_valid, b8.in_ready, b8.busy); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            if (b8.out_valid !== 1'b0) n++;
            @(posedge clk); #1;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL abort_discard got %0d valid cycles exp 0", n); end
        run8(8'd255, 8'd1, q, r, dz, lat);
        checks++; if ({q, r, dz} !== {8'd255, 8'd0, 1'b0})
            begin errors++; $display("FAIL abort_next got %0d/%0d/%b exp 255/0/0", q, r, dz); end
    endtask

    task automatic test_sign_mode;
        logic [7:0] q, r; logic dz; int lat;
`ifdef DIV_SIGNED_EN
        run8(8'hF9, 8'd2, q, r, dz, lat);
        checks++; if ({q, r} !== {8'hFD, 8'hFF}) begin errors++; $display("FAIL signed_m7_2 got %h/%h exp fd/ff", q, r); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL signed_latency got %0d exp 9", lat); end
        run8(8'h80, 8'hFF, q, r, dz, lat);
        checks++; if ({q, r, dz} !== {8'h80, 8'h00, 1'b0}) begin errors++; $display("FAIL signed_min_m1 got %h/%h/%b exp 80/00/0", q, r, dz); end
        run8(8'hF9, 8'h00, q, r, dz, lat);
        checks++; if ({q, r, dz} !== {8'hFF, 8'hF9, 1'b1}) begin errors++; $display("FAIL signed_dz got %h/%h/%b exp ff/f9/1", q, r, dz); end
`else
        run8(8'hF9, 8'd2, q, r, dz, lat);
        checks++; if ({q, r} !== {8'd124, 8'd1}) begin errors++; $display("FAIL unsigned_f9_2 got %0d/%0d exp 124/1", q, r); end
        run8(8'h80, 8'hFF, q, r, dz, lat);
        checks++; if ({q, r} !== {8'd0, 8'h80}) begin errors++; $display("FAIL unsigned_80_ff got %h/%h exp 00/80", q, r); end
`endif
    endtask

    task automatic test_legacy4;
        logic [3:0] q, r; logic dz; int lat;
        logic [31:0] eq, er; logic edz;
        logic [3:0] lq [4] = '{4'd15, 4'd7, 4'd5, 4'd3};
        logic [3:0] lr [4] = '{4'd0, 4'd1, 4'd0, 4'd3};
        for (int i = 0; i < 4; i++) begin
            run4(4'd15, 4'(i + 1), q, r, dz, lat);
`ifdef DIV_SIGNED_EN
            ref_div(4, 32'd15, 32'(i + 1), eq, er, edz);
`else
            eq = {28'd0, lq[i]}; er = {28'd0, lr[i]}; edz = 1'b0;
`endif
            checks++; if ({q, r, dz} !== {eq[3:0], er[3:0], edz})
                begin errors++; $display("FAIL legacy4 15/%0d got %0d/%0d/%b exp %0d/%0d/%b", i + 1, q, r, dz, eq[3:0], er[3:0], edz); end
            checks++; if (lat !== 5) begin errors++; $display("FAIL legacy4_latency 15/%0d got %0d exp 5", i + 1, lat); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ta [2] = '{8'd77, 8'd250};
        logic [7:0] tb [2] = '{8'd5, 8'd13};
        logic [31:0] eq, er; logic edz;
        int acc [$];
        int k = 0;
        int got = 0;
        logic pend;
        b8.dividend = ta[0]; b8.divisor = tb[0]; b8.in_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (b8.out_valid === 1'b1 && got < 2) begin
                ref_div(8, 32'(ta[got]), 32'(tb[got]), eq, er, edz);
                checks++; if ({b8.quotient, b8.remainder} !== {eq[7:0], er[7:0]})
                    begin errors++; $display("FAIL b2b_result %0d got %h/%h exp %h/%h", got, b8.quotient, b8.remainder, eq[7:0], er[7:0]); end
                got++;
            end
            pend = b8.in_valid && b8.in_ready;
            @(posedge clk); #1;
            if (pend) begin
                acc.push_back(cyc);
                k++;
                if (k < 2) begin b8.dividend = ta[k]; b8.divisor = tb[k]; end
                else b8.in_valid = 1'b0;
            end
        end
        b8.in_valid = 1'b0;
        checks++; if (got !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got); end
        checks++;
        if (acc.size() != 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc.size()); end
        else if (acc[1] - acc[0] != 10) begin errors++; $display("FAIL b2b_period got %0d exp 10", acc[1] - acc[0]); end
    endtask

    task automatic test_random;
        logic [7:0] a, b, q, r; logic dz; int lat, sel;
        logic [31:0] eq, er; logic edz;
        for (int i = 0; i < 150; i++) begin
            a   = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            b   = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd1 : (sel == 2) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 9) == 0) a = 8'h80;
            run8(a, b, q, r, dz, lat);
            ref_div(8, 32'(a), 32'(b), eq, er, edz);
            checks++; if (q !== eq[7:0]) begin errors++; $display("FAIL rand_quot %h/%h got %h exp %h", a, b, q, eq[7:0]); end
            checks++; if (r !== er[7:0]) begin errors++; $display("FAIL rand_rem %h/%h got %h exp %h", a, b, r, er[7:0]); end
            checks++; if (dz !== edz)    begin errors++; $display("FAIL rand_dz %h/%h got %b exp %b", a, b, dz, edz); end
            checks++; if (lat !== (edz ? 1 : 9)) begin errors++; $display("FAIL rand_latency %h/%h got %0d exp %0d", a, b, lat, edz ? 1 : 9); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_reset_abort();
        test_sign_mode();
        test_legacy4();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
